// File: rtl/mips_pipe_regs_hz_if.sv
// Signal bundle between the pipeline register bank and the fetch, decode,
// ALU, data-memory and writeback blocks that surround it.
interface mips_pipe_regs_hz_if #(
   parameter int PC_W    = 10,
   parameter int DATA_W  = 32,
   parameter int ALUOP_W = 4
);
   logic               STALL;
   logic               FLUSH;
   logic [PC_W-1:0]    IF_PC4;
   logic [31:0]        IF_INSTR;
   logic [DATA_W-1:0]  ID_RD1;
   logic [DATA_W-1:0]  ID_RD2;
   logic               ID_REGDST;
   logic               ID_ALUSRC;
   logic [ALUOP_W-1:0] ID_ALUOP;
   logic [1:0]         ID_MEMRW;
   logic               ID_MEMTOREG;
   logic               ID_REGWE;
   logic               ID_BRANCH;
   logic [DATA_W-1:0]  EX_ALU_RESULT;
   logic [DATA_W-1:0]  MEM_READ_DATA;

   logic [31:0]        ID_INSTR;
   logic               ID_VALID;
   logic [4:0]         ID_RS;
   logic [4:0]         ID_RT;
   logic [4:0]         ID_RDF;
   logic [DATA_W-1:0]  EX_RD1;
   logic [DATA_W-1:0]  EX_RD2;
   logic [DATA_W-1:0]  EX_IMM;
   logic [ALUOP_W-1:0] EX_ALUOP;
   logic               EX_ALUSRC;
   logic               EX_VALID;
   logic               MEM_RE;
   logic               MEM_WE;
   logic               MEM_BRANCH;
   logic [PC_W-1:0]    MEM_BRANCH_PC;
   logic [DATA_W-1:0]  MEM_ADDR;
   logic [DATA_W-1:0]  MEM_WDATA;
   logic [DATA_W-1:0]  WB_DATA;
   logic [4:0]         WB_REG;
   logic               WB_WE;

   modport master (
      output STALL, FLUSH, IF_PC4, IF_INSTR, ID_RD1, ID_RD2, ID_REGDST, ID_ALUSRC,
             ID_ALUOP, ID_MEMRW, ID_MEMTOREG, ID_REGWE, ID_BRANCH, EX_ALU_RESULT,
             MEM_READ_DATA,
      input  ID_INSTR, ID_VALID, ID_RS, ID_RT, ID_RDF, EX_RD1, EX_RD2, EX_IMM,
             EX_ALUOP, EX_ALUSRC, EX_VALID, MEM_RE, MEM_WE, MEM_BRANCH, MEM_BRANCH_PC,
             MEM_ADDR, MEM_WDATA, WB_DATA, WB_REG, WB_WE
   );

   modport slave (
      input  STALL, FLUSH, IF_PC4, IF_INSTR, ID_RD1, ID_RD2, ID_REGDST, ID_ALUSRC,
             ID_ALUOP, ID_MEMRW, ID_MEMTOREG, ID_REGWE, ID_BRANCH, EX_ALU_RESULT,
             MEM_READ_DATA,
      output ID_INSTR, ID_VALID, ID_RS, ID_RT, ID_RDF, EX_RD1, EX_RD2, EX_IMM,
             EX_ALUOP, EX_ALUSRC, EX_VALID, MEM_RE, MEM_WE, MEM_BRANCH, MEM_BRANCH_PC,
             MEM_ADDR, MEM_WDATA, WB_DATA, WB_REG, WB_WE
   );
endinterface

// File: rtl/mips_pipe_regs_hz.sv
// Four-stage MIPS pipeline register bank (IF/ID, ID/EX, EX/MEM, MEM/WB) with
// per-stage valid bits, stall bubbles, branch flush and valid-gated strobes.
module mips_pipe_regs_hz #(
   parameter int PC_W    = 10,
   parameter int DATA_W  = 32,
   parameter int ALUOP_W = 4
) (
   input  logic               CLOCK,
   input  logic               RESET,
   mips_pipe_regs_hz_if.slave bus
);
   logic               ifid_valid;
   logic [31:0]        ifid_instr;
   logic [PC_W-1:0]    ifid_pc4;

   logic               idex_valid;
   logic [DATA_W-1:0]  idex_rd1, idex_rd2, idex_imm;
   logic [PC_W-1:0]    idex_pc4;
   logic [4:0]         idex_dest;
   logic [ALUOP_W-1:0] idex_aluop;
   logic               idex_alusrc, idex_memtoreg, idex_regwe, idex_branch;
   logic [1:0]         idex_memrw;

   logic               exmem_valid;
   logic [DATA_W-1:0]  exmem_addr, exmem_wdata;
   logic [PC_W-1:0]    exmem_bpc;
   logic [4:0]         exmem_dest;
   logic [1:0]         exmem_memrw;
   logic               exmem_memtoreg, exmem_regwe, exmem_branch;

   logic               memwb_valid, memwb_regwe;
   logic [DATA_W-1:0]  memwb_data;
   logic [4:0]         memwb_dest;

   logic [DATA_W-1:0]  id_imm;
   logic [4:0]         id_dest;
   logic [PC_W-1:0]    ex_target;

   assign id_imm    = {{(DATA_W-16){ifid_instr[15]}}, ifid_instr[15:0]};
   assign id_dest   = bus.ID_REGDST ? ifid_instr[15:11] : ifid_instr[20:16];
   // Only the low PC_W-2 immediate bits survive the shift, so the sum wraps mod 2^PC_W.
   assign ex_target = idex_pc4 + {idex_imm[PC_W-3:0], 2'b00};

   // NOTE: every pipeline register uses <= so all stages sample the old values of the stage before.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         ifid_valid <= 1'b0;
         ifid_instr <= '0;
         ifid_pc4   <= '0;
      end else if (bus.FLUSH) begin
         ifid_valid <= 1'b0;
         ifid_instr <= '0;
         ifid_pc4   <= '0;
      end else if (!bus.STALL) begin
         ifid_valid <= 1'b1;
         ifid_instr <= bus.IF_INSTR;
         ifid_pc4   <= bus.IF_PC4;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         idex_valid <= 1'b0;  idex_rd1 <= '0;  idex_rd2 <= '0;  idex_imm <= '0;
         idex_pc4   <= '0;    idex_dest <= '0; idex_aluop <= '0;
         idex_alusrc <= 1'b0; idex_memrw <= '0; idex_memtoreg <= 1'b0;
         idex_regwe  <= 1'b0; idex_branch <= 1'b0;
      end else begin
         // NOTE: data fields load even into a bubble; clearing valid and controls is enough.
         idex_rd1  <= bus.ID_RD1;
         idex_rd2  <= bus.ID_RD2;
         idex_imm  <= id_imm;
         idex_pc4  <= ifid_pc4;
         idex_dest <= id_dest;
         if (bus.FLUSH || bus.STALL) begin
            idex_valid <= 1'b0;  idex_aluop <= '0;   idex_alusrc <= 1'b0;
            idex_memrw <= '0;    idex_memtoreg <= 1'b0;
            idex_regwe <= 1'b0;  idex_branch <= 1'b0;
         end else begin
            idex_valid    <= ifid_valid;
            idex_aluop    <= bus.ID_ALUOP;
            idex_alusrc   <= bus.ID_ALUSRC;
            idex_memrw    <= bus.ID_MEMRW;
            idex_memtoreg <= bus.ID_MEMTOREG;
            idex_regwe    <= bus.ID_REGWE;
            idex_branch   <= bus.ID_BRANCH;
         end
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         exmem_valid <= 1'b0; exmem_addr <= '0;  exmem_wdata <= '0; exmem_bpc <= '0;
         exmem_dest  <= '0;   exmem_memrw <= '0; exmem_memtoreg <= 1'b0;
         exmem_regwe <= 1'b0; exmem_branch <= 1'b0;
      end else begin
         exmem_addr  <= bus.EX_ALU_RESULT;
         exmem_wdata <= idex_rd2;
         exmem_bpc   <= ex_target;
         exmem_dest  <= idex_dest;
         if (bus.FLUSH) begin
            exmem_valid <= 1'b0;  exmem_memrw <= '0; exmem_memtoreg <= 1'b0;
            exmem_regwe <= 1'b0;  exmem_branch <= 1'b0;
         end else begin
            exmem_valid    <= idex_valid;
            exmem_memrw    <= idex_memrw;
            exmem_memtoreg <= idex_memtoreg;
            exmem_regwe    <= idex_regwe;
            exmem_branch   <= idex_branch;
         end
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         memwb_valid <= 1'b0;
         memwb_regwe <= 1'b0;
         memwb_data  <= '0;
         memwb_dest  <= '0;
      end else begin
         memwb_valid <= exmem_valid;
         memwb_regwe <= exmem_regwe;
         memwb_data  <= exmem_memtoreg ? bus.MEM_READ_DATA : exmem_addr;
         memwb_dest  <= exmem_dest;
      end
   end

   assign bus.ID_INSTR      = ifid_instr;
   assign bus.ID_VALID      = ifid_valid;
   assign bus.ID_RS         = ifid_instr[25:21];
   assign bus.ID_RT         = ifid_instr[20:16];
   assign bus.ID_RDF        = ifid_instr[15:11];
   assign bus.EX_RD1        = idex_rd1;
   assign bus.EX_RD2        = idex_rd2;
   assign bus.EX_IMM        = idex_imm;
   assign bus.EX_ALUOP      = idex_aluop;
   assign bus.EX_ALUSRC     = idex_alusrc;
   assign bus.EX_VALID      = idex_valid;
   assign bus.MEM_RE        = exmem_memrw[0] & exmem_valid;
   assign bus.MEM_WE        = exmem_memrw[1] & exmem_valid;
   assign bus.MEM_BRANCH    = exmem_branch & exmem_valid;
   assign bus.MEM_BRANCH_PC = exmem_bpc;
   assign bus.MEM_ADDR      = exmem_addr;
   assign bus.MEM_WDATA     = exmem_wdata;
   assign bus.WB_DATA       = memwb_data;
   assign bus.WB_REG        = memwb_dest;
   assign bus.WB_WE         = memwb_regwe & memwb_valid;
endmodule
